// File: rtl/layer_4_maxpool.sv
// layer_4_maxpool: streaming 2x2 / stride-2 max-pool for one fp32 feature-map
// channel. Pixels arrive in raster order with arbitrary gaps. Pooled pixels
// leave in raster order as registered one-cycle strobes.
//
// Optional feature: define LAYER_4_MAXPOOL_RELU_EN to clamp every pooled
// result whose sign bit is set (including -0.0 and negative NaN) to +0.0.
//
// IMG_SIZE must be even and at least 2.
module layer_4_maxpool #(
   parameter int DATA_WIDTH = 32,
   parameter int IMG_SIZE   = 104
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  valid_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out
);

   localparam int HALF   = IMG_SIZE / 2;
   localparam int CNT_W  = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
   localparam int BUF_AW = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IMG_SIZE - 1);

   // Raster position of the pixel currently on data_in.
   logic [CNT_W-1:0]      col;
   logic [CNT_W-1:0]      row;
   // Left pixel of the current horizontal pair.
   logic [DATA_WIDTH-1:0] pair_q;
   // Pair maxima of the even row, one entry per output column.
   logic [DATA_WIDTH-1:0] row_buf [HALF];

   logic                  col_odd;
   logic                  row_odd;
   logic [BUF_AW-1:0]     buf_idx;
   logic [DATA_WIDTH-1:0] buf_rd;
   logic [DATA_WIDTH-1:0] pair_max;
   logic [DATA_WIDTH-1:0] pool_max;
   logic [DATA_WIDTH-1:0] pool_out;

   // Total order on fp32 bit patterns: positives above negatives, negatives
   // reversed so that larger magnitude ranks lower. -0.0 ranks just below +0.0.
   function automatic logic [DATA_WIDTH-1:0] cmp_key(input logic [DATA_WIDTH-1:0] v);
      if (v[DATA_WIDTH-1])
         return {1'b0, ~v[DATA_WIDTH-2:0]};
      else
         return {1'b1, v[DATA_WIDTH-2:0]};
   endfunction

   // Larger key wins; on a tie the first (earlier in stream) operand is kept.
   function automatic logic [DATA_WIDTH-1:0] max2(input logic [DATA_WIDTH-1:0] first,
                                                  input logic [DATA_WIDTH-1:0] second);
      return (cmp_key(second) > cmp_key(first)) ? second : first;
   endfunction

   assign col_odd = col[0];
   assign row_odd = row[0];
   assign buf_idx = BUF_AW'(col >> 1);
   assign buf_rd  = row_buf[buf_idx];

   // Pair and window maxima, plus the optional negative clamp.
   // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
   always_comb begin
      pair_max = max2(pair_q, data_in);
      pool_max = max2(buf_rd, pair_max);
      pool_out = pool_max;
`ifdef LAYER_4_MAXPOOL_RELU_EN
      if (pool_max[DATA_WIDTH-1])
         pool_out = '0;
`endif
   end

   // Raster counters, pair register and registered pooled output.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         col       <= '0;
         row       <= '0;
         pair_q    <= '0;
         data_out  <= '0;
         valid_out <= 1'b0;
      end else begin
         valid_out <= 1'b0;
         if (valid_in) begin
            if (!col_odd)
               pair_q <= data_in;
            if (col_odd && row_odd) begin
               data_out  <= pool_out;
               valid_out <= 1'b1;
            end
            if (col == LAST_IDX) begin
               col <= '0;
               row <= (row == LAST_IDX) ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

   // Even-row pair maxima are parked here until the odd row completes the window.
   // NOTE: the row buffer has no reset; each entry is written on the even row before the odd row reads it.
   always_ff @(posedge Clk) begin
      if (!Rst && valid_in && col_odd && !row_odd)
         row_buf[buf_idx] <= pair_max;
   end

endmodule

// File: tb/tb_layer_4_maxpool.sv
// Scoreboard bench for layer_4_maxpool with a 4x4 image. The driver pushes the
// hand-computed pooled value and its due cycle when it issues the last pixel of
// each window; an independent monitor pops and compares on every strobe.
module tb_layer_4_maxpool;

   localparam int DW  = 32;
   localparam int IMG = 4;
   localparam int NPX = IMG * IMG;
   localparam int NRS = (IMG / 2) * (IMG / 2);

   typedef logic [DW-1:0] frame_t [NPX];
   typedef logic [DW-1:0] res_t   [NRS];
   typedef struct {
      logic [DW-1:0] data;
      int            cyc;
   } exp_t;

   logic          Clk;
   logic          Rst;
   logic [DW-1:0] data_in;
   logic          valid_in;
   logic [DW-1:0] data_out;
   logic          valid_out;

   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc      = 0;
   exp_t sb [$];

   layer_4_maxpool #(
      .DATA_WIDTH (DW),
      .IMG_SIZE   (IMG)
   ) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .data_in   (data_in),
      .valid_in  (valid_in),
      .data_out  (data_out),
      .valid_out (valid_out)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   // fp32 encoding of a positive integer (exact for the small values used).
   function automatic logic [DW-1:0] fp(input int n);
      int e;
      int mant;
      e = 0;
      while ((n >> (e + 1)) != 0) e++;
      mant = (n - (1 << e)) << (23 - e);
      return {1'b0, 8'(127 + e), 23'(mant)};
   endfunction

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge Clk);
         valid_in = 1'b0;
      end
   endtask

   // Drive the first n pixels of a frame; with gap set, each pixel is followed by an idle cycle.
   task automatic send_frame(input frame_t px, input bit gap, input res_t ex, input int n);
      for (int i = 0; i < n; i++) begin
         exp_t e;
         @(negedge Clk);
         data_in  = px[i];
         valid_in = 1'b1;
         if (((i % IMG) % 2 == 1) && ((i / IMG) % 2 == 1)) begin
            e.data = ex[((i / IMG) / 2) * (IMG / 2) + (i % IMG) / 2];
            e.cyc  = cyc + 1;
            sb.push_back(e);
         end
         if (gap) begin
            @(negedge Clk);
            valid_in = 1'b0;
            data_in  = 32'hdeadbeef;
         end
      end
   endtask

   // Monitor: every strobe must match the oldest expectation in value and cycle.
   bit prev_valid = 1'b0;
   always @(negedge Clk) begin
      if (!Rst && valid_out) begin
         n_checks++;
         if (prev_valid) begin
            n_errors++;
            $display("FAIL back_to_back_strobe: valid_out high in consecutive cycles at cycle %0d", cyc);
         end
         n_checks++;
         if (sb.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_strobe: got %h at cycle %0d, expected no strobe", data_out, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (data_out !== e.data || cyc != e.cyc)
            begin
               n_errors++;
               $display("FAIL pooled_value: got %h at cycle %0d expected %h at cycle %0d",
                        data_out, cyc, e.data, e.cyc);
            end
         end
      end
      prev_valid = valid_out;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      frame_t basic, second, sign1, sign2;
      res_t   basic_ex, second_ex, sign1_ex, sign2_ex;

      for (int i = 0; i < NPX; i++) begin
         basic[i]  = fp(i + 1);
         second[i] = fp(i + 17);
      end
      basic_ex  = '{32'h40c00000, 32'h41000000, 32'h41600000, 32'h41800000};
      second_ex = '{32'h41b00000, 32'h41c00000, 32'h41f00000, 32'h42000000};

      // Top-left window {-2.0, -0.5 / -1.0, -3.0}; other windows as in basic.
      sign1    = basic;
      sign1[0] = 32'hc0000000;
      sign1[1] = 32'hbf000000;
      sign1[4] = 32'hbf800000;
      sign1[5] = 32'hc0400000;
`ifdef LAYER_4_MAXPOOL_RELU_EN
      sign1_ex = '{32'h00000000, 32'h41000000, 32'h41600000, 32'h41800000};
`else
      sign1_ex = '{32'hbf000000, 32'h41000000, 32'h41600000, 32'h41800000};
`endif
      // Top-left window {-0.0, +0.0 / -1.0, -1.0}: +0.0 must beat -0.0.
      sign2    = basic;
      sign2[0] = 32'h80000000;
      sign2[1] = 32'h00000000;
      sign2[4] = 32'hbf800000;
      sign2[5] = 32'hbf800000;
      sign2_ex = '{32'h00000000, 32'h41000000, 32'h41600000, 32'h41800000};

      Rst      = 1'b1;
      valid_in = 1'b0;
      data_in  = '0;
      repeat (2) @(negedge Clk);
      check("reset_data_out", data_out, '0);
      check("reset_valid_out", {31'b0, valid_out}, '0);
      Rst = 1'b0;

      // Basic frame followed immediately by a second frame: exercises the frame wrap.
      send_frame(basic, 1'b0, basic_ex, NPX);
      send_frame(second, 1'b0, second_ex, NPX);
      idle(4);

      // Same data with valid_in toggling every cycle.
      send_frame(basic, 1'b1, basic_ex, NPX);
      idle(4);

      // Sign ordering windows.
      send_frame(sign1, 1'b0, sign1_ex, NPX);
      send_frame(sign2, 1'b0, sign2_ex, NPX);
      idle(4);

      // Partial frame of 9 pixels, then reset with valid_in also high.
      send_frame(basic, 1'b0, basic_ex, 9);
      @(negedge Clk);
      Rst      = 1'b1;
      valid_in = 1'b1;
      data_in  = fp(99);
      @(negedge Clk);
      check("midframe_reset_data_out", data_out, '0);
      check("midframe_reset_valid_out", {31'b0, valid_out}, '0);
      Rst      = 1'b0;
      valid_in = 1'b0;
      send_frame(basic, 1'b0, basic_ex, NPX);
      idle(6);

      check("scoreboard_drained", 32'(sb.size()), '0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/layer_4_maxpool.md
# layer_4_maxpool

Streaming 2x2 / stride-2 max-pooling stage for one YOLOv3-Tiny feature-map channel. Consumes the raster-order IEEE-754 single-precision pixel stream produced by a per-channel layer-4 feature-map block, after channel summation and activation. Emits the pooled (IMG_SIZE/2)x(IMG_SIZE/2) map in raster order for the next layer. One instance per output channel; no backpressure.

## Interface
- DATA_WIDTH, 32, pixel width; fp32 only.
- IMG_SIZE, 104, input width and height in pixels; must be even and at least 2.
- Clk  input  1  rising-edge clock.
- Rst  input  1  synchronous, active-high reset.
- data_in  input  DATA_WIDTH  fp32 pixel, raster order, row 0 first.
- valid_in  input  1  data_in valid this cycle; gaps of any length allowed.
- data_out  output  DATA_WIDTH  pooled fp32 pixel.
- valid_out  output  1  one-cycle strobe per pooled pixel.

## Operation
- Counters:
  - col counts 0..IMG_SIZE-1 and advances only on valid_in.
  - row counts 0..IMG_SIZE-1 and advances when col wraps.
  - row wraps to 0 after the last pixel. The next frame starts with no idle cycle.
- Compare key (defines max):
  - key = {1, bits[30:0]} if sign=0, else {0, ~bits[30:0]}.
  - Larger unsigned key wins.
  - Gives -0 < +0. No special NaN handling; NaN orders by bit pattern.
  - On equal keys the earlier operand in stream order is kept.
- Row buffer: IMG_SIZE/2 entries x DATA_WIDTH, indexed by col>>1.
- Even row, even col: hold data_in in pair register P.
- Even row, odd col: write max(P, data_in) to buf[col>>1].
- Odd row, even col: hold data_in in P.
- Odd row, odd col: output max(buf[col>>1], max(P, data_in)) and pulse valid_out.
  - Operand order for ties: buf first, then P, then data_in.
- Output order: pooled raster order. Exactly (IMG_SIZE/2)^2 valid_out pulses per frame.
- The buffer is never read before being written in the same frame, so it needs no reset.
- Reset:
  - data_out=0, valid_out=0, col=0, row=0, P=0.
  - Reset mid-frame discards the partial frame. The first valid_in after reset is pixel (0,0).
  - Rst has priority over valid_in in the same cycle.

## Timing
- Output is registered.
- Latency: valid_out asserts the cycle after the valid_in that carries the bottom-right pixel of a 2x2 window (odd row, odd col).
- data_out holds its last value between strobes. It is updated only when valid_out is asserted.
- valid_out never asserts in two consecutive cycles. Throughput is one input pixel per cycle.
- Wrap at the end of a frame: the pixel after (IMG_SIZE-1, IMG_SIZE-1) is treated as (0,0) of the next frame, even if it arrives in the very next cycle.
- valid_in low: all state frozen, valid_out=0 next cycle.

## Configuration
- LAYER_4_MAXPOOL_RELU_EN defined:
  - Any pooled result with sign bit 1 is replaced by 32'h00000000 before registering. This includes -0.0 and negative NaN.
  - Latency is unchanged.
- Not defined: the pooled value is passed through unmodified.

## Test plan
- Basic pooling (IMG_SIZE=4, macro off):
  - Stimulus: pixels 1.0..16.0 (32'h3f800000 ... 32'h41800000), back-to-back.
  - Expect 4 strobes: 6.0, 8.0, 14.0, 16.0 (32'h40c00000, 32'h41000000, 41600000, 41800000).
  - Each strobe arrives 1 cycle after input pixels 6, 8, 14 and 16 respectively.
- Sign handling:
  - Stimulus: window {-2.0, -0.5, -1.0, -3.0}. Expect 32'hbf000000.
  - Stimulus: window {-0.0, +0.0, -1.0, -1.0}. Expect 32'h00000000.
- Gapped input: same stream as the basic test with valid_in toggling 1/0 every cycle.
  - Identical data values, each one cycle after its window's last input.
  - valid_out never high on an idle cycle.
- Frame wrap: two 4x4 frames back-to-back, the second being 17.0..32.0.
  - 8 strobes total; the second frame yields 22.0, 24.0, 30.0, 32.0.
- Reset mid-frame: assert Rst after 9 pixels, then send a full fresh frame.
  - Only that frame's 4 results appear; data_out=0 and valid_out=0 the cycle after Rst.
- RELU macro on: window {-2.0, -0.5, -1.0, -3.0} -> 32'h00000000; basic test unchanged.
